ctrl_sequencer: RTL

- Multi-cycle control unit for the 8-bit datapath. It is the driving end of the ALU interface.
- Fetches 9-bit instructions and decodes them into the ALU controls (Aluop, Alu_en, logical_shift, compare_type, Num, Num_to_put).
- Consumes the ALU's Grt/Lss/Eql flags for conditional branches.
- Owns the program counter, the flag register, register-file and data-memory strobes, and Done.

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/instr_decode.sv | 100 ++++++++++
 rtl/ctrl_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the 9-bit control sequencer:
// opcodes, extended sub-ops, branch conditions and FSM states.
package ctrl_pkg;

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_PUT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SHF  = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;
    localparam logic [2:0] OP_FLIP = 3'b110;
    localparam logic [2:0] OP_EXT  = 3'b111;

    localparam logic [1:0] EXT_LD   = 2'b00;
    localparam logic [1:0] EXT_ST   = 2'b01;
    localparam logic [1:0] EXT_BR   = 2'b10;
    localparam logic [1:0] EXT_HALT = 2'b11;

    localparam logic [1:0] BR_ALW = 2'b00;
    localparam logic [1:0] BR_EQ  = 2'b01;
    localparam logic [1:0] BR_GT  = 2'b10;
    localparam logic [1:0] BR_LT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // gle = registered {G, L, E}
    function automatic logic br_taken(input logic [1:0] cond,
                                      input logic [2:0] gle);
        logic t;
        unique case (cond)
            BR_ALW: t = 1'b1;
            BR_EQ:  t = gle[0];
            BR_GT:  t = gle[2];
            BR_LT:  t = gle[1];
        endcase
        return t;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register into the
// EXEC-phase ALU controls, register addresses and strobes.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [8:0] ir,
    output logic [2:0] aluop,
    output logic       alu_en,
    output logic       logical_shift,
    output logic       compare_type,
    output logic [7:0] num,
    output logic [7:0] num_to_put,
    output logic [2:0] rd_addr_a,
    output logic [2:0] rd_addr_b,
    output logic [2:0] wr_addr,
    output logic       reg_wr_en,
    output logic       mem_rd_en,
    output logic       mem_wr_en,
    output logic [1:0] br_lut_idx,
    output logic       is_cmp,
    output logic       is_flip,
    output logic       is_ld,
    output logic       is_br,
    output logic       is_halt
);

    logic [2:0] op;
    logic [2:0] ra;
    logic [2:0] rb;

    assign op = ir[8:6];
    assign ra = ir[5:3];
    assign rb = ir[2:0];

    always_comb begin
        aluop         = '0;
        alu_en        = 1'b0;
        logical_shift = 1'b0;
        compare_type  = 1'b0;
        num           = '0;
        num_to_put    = '0;
        rd_addr_a     = '0;
        rd_addr_b     = '0;
        wr_addr       = '0;
        reg_wr_en     = 1'b0;
        mem_rd_en     = 1'b0;
        mem_wr_en     = 1'b0;
        br_lut_idx    = '0;
        is_cmp        = 1'b0;
        is_flip       = 1'b0;
        is_ld         = 1'b0;
        is_br         = 1'b0;
        is_halt       = 1'b0;

        if (op != OP_EXT) begin
            aluop     = op;
            alu_en    = 1'b1;
            rd_addr_a = ra;
            rd_addr_b = rb;
            wr_addr   = ra;
            reg_wr_en = 1'b1;
        end

        unique case (op)
            OP_PUT: num_to_put = {5'b0, rb};
            OP_SHF: begin
                logical_shift = ir[2];
                rd_addr_b     = {1'b0, ir[1:0]};
            end
            OP_CMP: begin
                compare_type = ir[2];
                rd_addr_b    = {1'b0, ir[1:0]};
                num          = {6'b0, ir[1:0]};
                reg_wr_en    = 1'b0;
                is_cmp       = 1'b1;
            end
            OP_FLIP: is_flip = 1'b1;
            // memory ops address through R0 on port A
            OP_EXT: begin
                unique case (ir[5:4])
                    EXT_LD: begin
                        mem_rd_en = 1'b1;
                        is_ld     = 1'b1;
                    end
                    EXT_ST: begin
                        mem_wr_en = 1'b1;
                        rd_addr_b = rb;
                    end
                    EXT_BR: begin
                        br_lut_idx = ir[1:0];
                        is_br      = 1'b1;
                    end
                    EXT_HALT: is_halt = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control FSM: owns the PC, instruction register,
// {G,L,E} flag register and drives the ALU/regfile/memory controls.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int PC_W = 10,
    parameter int IW   = 9
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [IW-1:0]   Instr,
    input  logic [PC_W-1:0] Br_target,
    input  logic            Grt,
    input  logic            Lss,
    input  logic            Eql,
    output logic [PC_W-1:0] Prog_ctr,
    output logic [1:0]      Br_lut_idx,
    output logic [2:0]      Aluop,
    output logic            Alu_en,
    output logic            logical_shift,
    output logic            compare_type,
    output logic [7:0]      Num,
    output logic [7:0]      Num_to_put,
    output logic [2:0]      Rd_addr_a,
    output logic [2:0]      Rd_addr_b,
    output logic [2:0]      Wr_addr,
    output logic            Reg_wr_en,
    output logic            Mem_rd_en,
    output logic            Mem_wr_en,
    output logic            Done
);

    state_t          state, state_nx;
    logic [IW-1:0]   ir;
    logic [2:0]      flags, flags_nx;
    logic [PC_W-1:0] pc_nx;
    logic            ir_ld;

    logic [2:0] d_aluop, d_rda, d_rdb, d_wr;
    logic [7:0] d_num, d_ntp;
    logic [1:0] d_lut;
    logic       d_alu_en, d_ls, d_ct, d_we, d_mrd, d_mwr;
    logic       d_cmp, d_flip, d_ld, d_br, d_halt;

    instr_decode u_dec (
        .ir            (ir[8:0]),
        .aluop         (d_aluop),
        .alu_en        (d_alu_en),
        .logical_shift (d_ls),
        .compare_type  (d_ct),
        .num           (d_num),
        .num_to_put    (d_ntp),
        .rd_addr_a     (d_rda),
        .rd_addr_b     (d_rdb),
        .wr_addr       (d_wr),
        .reg_wr_en     (d_we),
        .mem_rd_en     (d_mrd),
        .mem_wr_en     (d_mwr),
        .br_lut_idx    (d_lut),
        .is_cmp        (d_cmp),
        .is_flip       (d_flip),
        .is_ld         (d_ld),
        .is_br         (d_br),
        .is_halt       (d_halt)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            Prog_ctr <= '0;
            ir       <= '0;
            flags    <= '0;
        end else begin
            state    <= state_nx;
            Prog_ctr <= pc_nx;
            flags    <= flags_nx;
            if (ir_ld)
                ir <= Instr;
        end
    end

    always_comb begin
        state_nx      = state;
        pc_nx         = Prog_ctr;
        flags_nx      = flags;
        ir_ld         = 1'b0;
        Br_lut_idx    = '0;
        Aluop         = '0;
        Alu_en        = 1'b0;
        logical_shift = 1'b0;
        compare_type  = 1'b0;
        Num           = '0;
        Num_to_put    = '0;
        Rd_addr_a     = '0;
        Rd_addr_b     = '0;
        Wr_addr       = '0;
        Reg_wr_en     = 1'b0;
        Mem_rd_en     = 1'b0;
        Mem_wr_en     = 1'b0;
        Done          = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nx = S_FETCH;
                    pc_nx    = '0;
                end
            end
            S_FETCH: begin
                ir_ld    = 1'b1;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                Br_lut_idx    = d_lut;
                Aluop         = d_aluop;
                Alu_en        = d_alu_en;
                logical_shift = d_ls;
                compare_type  = d_ct;
                Num           = d_num;
                Num_to_put    = d_ntp;
                Rd_addr_a     = d_rda;
                Rd_addr_b     = d_rdb;
                Wr_addr       = d_wr;
                Reg_wr_en     = d_we;
                Mem_rd_en     = d_mrd;
                Mem_wr_en     = d_mwr;
                state_nx      = S_FETCH;
                pc_nx         = Prog_ctr + 1'b1;
                if (d_cmp)
                    flags_nx = {Grt, Lss, Eql};
                if (d_flip)
                    flags_nx = '0;
                if (d_br && br_taken(ir[3:2], flags))
                    pc_nx = Br_target;
                // LD advances the PC in WB; HALT parks it
                if (d_ld) begin
                    state_nx = S_MEM;
                    pc_nx    = Prog_ctr;
                end
                if (d_halt) begin
                    state_nx = S_HALT;
                    pc_nx    = Prog_ctr;
                end
            end
            S_MEM: state_nx = S_WB;
            S_WB: begin
                Reg_wr_en = 1'b1;
                Wr_addr   = ir[2:0];
                pc_nx     = Prog_ctr + 1'b1;
                state_nx  = S_FETCH;
            end
            S_HALT: begin
                Done = 1'b1;
                if (Start) begin
                    state_nx = S_FETCH;
                    pc_nx    = '0;
                    flags_nx = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
